// File: rtl/jpeg_pkg.sv
// Shared JPEG front-end definitions: component encoding, block geometry and
// pixel byte-lane layout used by the colour converter and block buffer.
package jpeg_pkg;

  typedef enum logic [1:0] {COMP_Y, COMP_CB, COMP_CR} comp_e;

  localparam int BLK_SAMPLES = 64;
  localparam int NUM_COMP    = 3;
  localparam int IDX_W       = 6;
  localparam int PIX_W       = 24;

  // Byte-lane offsets inside a packed {Cr, Cb, Y} pixel
  localparam int Y_LSB  = 0;
  localparam int CB_LSB = 8;
  localparam int CR_LSB = 16;

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BLK_SAMPLES - 1);
  localparam comp_e            COMP_LAST = comp_e'(NUM_COMP - 1);

  // Extract one component byte from a packed pixel
  function automatic logic [7:0] comp_slice(input logic [PIX_W-1:0] w, input comp_e c);
    logic [7:0] s;
    case (c)
      COMP_CB: s = w[CB_LSB +: 8];
      COMP_CR: s = w[CR_LSB +: 8];
      default: s = w[Y_LSB +: 8];
    endcase
    return s;
  endfunction

  // Component that follows c in the planar replay order
  function automatic comp_e comp_next(input comp_e c);
    comp_e n;
    case (c)
      COMP_Y:  n = COMP_CB;
      COMP_CB: n = COMP_CR;
      default: n = COMP_Y;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ycbcr_pingpong_mem.sv
// Two-bank pixel store, 64 packed YCbCr words per bank. One synchronous
// write port and one combinational read port; contents are not reset.
module ycbcr_pingpong_mem
  import jpeg_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic             wbank,
  input  logic [IDX_W-1:0] widx,
  input  logic [PIX_W-1:0] wdata,
  input  logic             rbank,
  input  logic [IDX_W-1:0] ridx,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem_q [2][BLK_SAMPLES];

  // Capture a pixel into the addressed bank slot
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wbank][widx] <= wdata;
    end
  end

  // Combinational read so the output register can load the next sample directly
  assign rdata = mem_q[rbank][ridx];

endmodule

// File: rtl/ycbcr_block_buffer.sv
// Ping-pong 8x8 block buffer: captures 64 packed YCbCr pixels per bank and
// replays each block as planar Y, Cb, Cr component blocks under valid/ready.
// Optional build macro YCBCR_LEVEL_SHIFT_EN converts output samples to
// two's complement (sample - 128); otherwise raw unsigned samples are sent.
module ycbcr_block_buffer
  import jpeg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [PIX_W-1:0] data_in,
  output logic             in_ready,
  output logic             overflow,
  output logic [7:0]       data_out,
  output logic [1:0]       comp_out,
  output logic             block_start,
  output logic             valid_out,
  input  logic             ready_in
);

  typedef enum logic {RD_IDLE, RD_DRAIN} rd_state_e;

  // Write side state
  logic             wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [1:0]       full_q, full_d;
  logic             overflow_q, overflow_d;

  // Read side state and output register
  rd_state_e        rd_state_q, rd_state_d;
  logic             rd_bank_q, rd_bank_d;
  comp_e            rd_comp_q, rd_comp_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [7:0]       data_q, data_d;
  logic             block_start_q, block_start_d;
  logic             valid_q, valid_d;

  // Inter-process control
  logic             we;
  logic             set_full;
  logic             clr_full;
  logic             load;
  logic             rbank;
  logic [IDX_W-1:0] ridx;
  logic [PIX_W-1:0] rdata;
  logic             xfer;

  ycbcr_pingpong_mem u_mem (
    .clk   (clk),
    .we    (we),
    .wbank (wr_bank_q),
    .widx  (wr_idx_q),
    .wdata (data_in),
    .rbank (rbank),
    .ridx  (ridx),
    .rdata (rdata)
  );

  // Write pointer advance, bank hand-off on the 64th pixel and drop detection
  always_comb begin
    we         = enable & ~full_q[wr_bank_q];
    overflow_d = enable & full_q[wr_bank_q];
    wr_idx_d   = wr_idx_q;
    wr_bank_d  = wr_bank_q;
    set_full   = 1'b0;
    if (we) begin
      wr_idx_d = wr_idx_q + 1'b1;
      if (wr_idx_q == IDX_LAST) begin
        set_full  = 1'b1;
        wr_bank_d = ~wr_bank_q;
      end
    end
  end

  // Full flags: drain completion frees one bank, capture completion fills the other
  always_comb begin
    full_d = full_q;
    if (clr_full) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (set_full) begin
      full_d[wr_bank_q] = 1'b1;
    end
  end

  // Read FSM: choose the next sample address and decide whether the output register loads
  always_comb begin
    xfer          = valid_q & ready_in;
    rd_state_d    = rd_state_q;
    rd_bank_d     = rd_bank_q;
    rd_comp_d     = rd_comp_q;
    rd_idx_d      = rd_idx_q;
    block_start_d = block_start_q;
    valid_d       = valid_q;
    clr_full      = 1'b0;
    load          = 1'b0;
    rbank         = rd_bank_q;
    ridx          = rd_idx_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (full_q[rd_bank_q]) begin
          rd_state_d = RD_DRAIN;
          rd_comp_d  = COMP_Y;
          rd_idx_d   = '0;
          ridx       = '0;
          load       = 1'b1;
        end
      end
      RD_DRAIN: begin
        if (xfer) begin
          if (rd_comp_q == COMP_LAST && rd_idx_q == IDX_LAST) begin
            clr_full  = 1'b1;
            rd_bank_d = ~rd_bank_q;
            rd_comp_d = COMP_Y;
            rd_idx_d  = '0;
            if (full_q[~rd_bank_q]) begin
              rbank = ~rd_bank_q;
              ridx  = '0;
              load  = 1'b1;
            end else begin
              rd_state_d    = RD_IDLE;
              valid_d       = 1'b0;
              block_start_d = 1'b0;
            end
          end else begin
            ridx     = rd_idx_q + 1'b1;
            rd_idx_d = rd_idx_q + 1'b1;
            if (rd_idx_q == IDX_LAST) begin
              rd_comp_d = comp_next(rd_comp_q);
            end
            load = 1'b1;
          end
        end
      end
      default: begin
        rd_state_d = RD_IDLE;
      end
    endcase
    if (load) begin
      valid_d       = 1'b1;
      block_start_d = (rd_idx_d == '0);
    end
  end

  // Output data: slice the selected component and optionally level-shift it
  always_comb begin
    logic [7:0] s;
    s      = comp_slice(rdata, rd_comp_d);
    data_d = data_q;
    if (load) begin
`ifdef YCBCR_LEVEL_SHIFT_EN
      data_d = {~s[7], s[6:0]};
`else
      data_d = s;
`endif
    end
  end

  // Write side registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      full_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      wr_idx_q   <= wr_idx_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  // Read side registers including the output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state_q    <= RD_IDLE;
      rd_bank_q     <= 1'b0;
      rd_comp_q     <= COMP_Y;
      rd_idx_q      <= '0;
      data_q        <= '0;
      block_start_q <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      rd_state_q    <= rd_state_d;
      rd_bank_q     <= rd_bank_d;
      rd_comp_q     <= rd_comp_d;
      rd_idx_q      <= rd_idx_d;
      data_q        <= data_d;
      block_start_q <= block_start_d;
      valid_q       <= valid_d;
    end
  end

  assign in_ready    = ~full_q[wr_bank_q];
  assign overflow    = overflow_q;
  assign data_out    = data_q;
  assign comp_out    = rd_comp_q;
  assign block_start = block_start_q;
  assign valid_out   = valid_q;

endmodule

// File: tb/tb_ycbcr_block_buffer.sv
// Directed self-checking bench for ycbcr_block_buffer. Honours
// YCBCR_LEVEL_SHIFT_EN in its expected-value model.
module tb_ycbcr_block_buffer;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [23:0] data_in;
  logic        in_ready;
  logic        overflow;
  logic [7:0]  data_out;
  logic [1:0]  comp_out;
  logic        block_start;
  logic        valid_out;
  logic        ready_in;

  int tests_run;
  int tests_failed;
  int cyc;

  logic [7:0] got_data[$];
  logic [1:0] got_comp[$];
  logic       got_bs[$];
  int         got_cyc[$];

  ycbcr_block_buffer dut (
    .clk         (clk),
    .rst         (rst_n),
    .enable      (enable),
    .data_in     (data_in),
    .in_ready    (in_ready),
    .overflow    (overflow),
    .data_out    (data_out),
    .comp_out    (comp_out),
    .block_start (block_start),
    .valid_out   (valid_out),
    .ready_in    (ready_in)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges the bench itself
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [23:0] pix(input int p);
    return {8'((128 + p) & 255), 8'((64 + p) & 255), 8'(p & 255)};
  endfunction

  // Expected sample k of a replayed block whose pixels are base..base+63
  function automatic logic [7:0] exp_sample(input int base, input int k);
    int p;
    int c;
    logic [7:0] s;
    p = base + (k % 64);
    c = k / 64;
    s = 8'((64 * c + p) & 255);
`ifdef YCBCR_LEVEL_SHIFT_EN
    s = s ^ 8'h80;
`endif
    return s;
  endfunction

  task automatic clear_log();
    got_data.delete();
    got_comp.delete();
    got_bs.delete();
    got_cyc.delete();
  endtask

  task automatic record();
    if (valid_out === 1'b1 && ready_in === 1'b1) begin
      got_data.push_back(data_out);
      got_comp.push_back(comp_out);
      got_bs.push_back(block_start);
      got_cyc.push_back(cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    record();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    enable   = 1'b0;
    data_in  = '0;
    ready_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_log();
  endtask

  task automatic drain(input int target, input int budget);
    ready_in = 1'b1;
    enable   = 1'b0;
    for (int n = 0; n < budget && got_data.size() < target; n++) tick();
    repeat (10) tick();
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    enable   = 1'b0;
    data_in  = '0;
    ready_in = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (data_out !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset data_out got=%h exp=00", data_out); end
    tests_run++;
    if (comp_out !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset comp_out got=%0d exp=0", comp_out); end
    tests_run++;
    if (block_start !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset block_start got=%b exp=0", block_start); end
    tests_run++;
    if (valid_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset valid_out got=%b exp=0", valid_out); end
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset overflow got=%b exp=0", overflow); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset in_ready got=%b exp=1", in_ready); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_log();
  endtask

  task automatic test_single_block();
    int feed_end;
    do_reset();
    ready_in = 1'b1;
    for (int i = 0; i < 64; i++) begin
      enable  = 1'b1;
      data_in = pix(i);
      tick();
    end
    enable   = 1'b0;
    feed_end = cyc;
    drain(192, 400);
    tests_run++;
    if (got_data.size() != 192) begin tests_failed++; $display("[TB] FAIL single count got=%0d exp=192", got_data.size()); end
    if (got_data.size() > 0) begin
      tests_run++;
      if (got_cyc[0] != feed_end + 1) begin tests_failed++; $display("[TB] FAIL single latency first_cyc=%0d exp=%0d", got_cyc[0], feed_end + 1); end
    end
    if (got_data.size() >= 192) begin
      tests_run++;
      if (got_cyc[191] - got_cyc[0] != 191) begin tests_failed++; $display("[TB] FAIL single contiguous span=%0d exp=191", got_cyc[191] - got_cyc[0]); end
    end
    for (int k = 0; k < got_data.size() && k < 192; k++) begin
      tests_run++;
      if (got_data[k] !== exp_sample(0, k) || got_comp[k] !== 2'(k / 64) || got_bs[k] !== (k % 64 == 0)) begin
        tests_failed++;
        $display("[TB] FAIL single xfer %0d got d=%h c=%0d bs=%b exp d=%h c=%0d bs=%b", k, got_data[k], got_comp[k], got_bs[k], exp_sample(0, k), k / 64, (k % 64 == 0));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] lfsr;
    logic        held;
    logic [7:0]  hd;
    logic [1:0]  hc;
    logic        hb;
    do_reset();
    ready_in = 1'b0;
    for (int i = 0; i < 64; i++) begin
      enable  = 1'b1;
      data_in = pix(i);
      tick();
    end
    enable = 1'b0;
    lfsr   = 16'hACE1;
    held   = 1'b0;
    hd     = '0;
    hc     = '0;
    hb     = 1'b0;
    for (int n = 0; n < 2000 && got_data.size() < 192; n++) begin
      ready_in = lfsr[0];
      lfsr     = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      @(negedge clk);
      if (held) begin
        tests_run++;
        if (valid_out !== 1'b1 || data_out !== hd || comp_out !== hc || block_start !== hb) begin
          tests_failed++;
          $display("[TB] FAIL bp stall hold got v=%b d=%h c=%0d bs=%b exp v=1 d=%h c=%0d bs=%b", valid_out, data_out, comp_out, block_start, hd, hc, hb);
        end
      end
      held = (valid_out === 1'b1) && !ready_in;
      hd   = data_out;
      hc   = comp_out;
      hb   = block_start;
      record();
      @(posedge clk);
      #1;
      cyc++;
    end
    drain(192, 0);
    tests_run++;
    if (got_data.size() != 192) begin tests_failed++; $display("[TB] FAIL bp count got=%0d exp=192", got_data.size()); end
    for (int k = 0; k < got_data.size() && k < 192; k++) begin
      tests_run++;
      if (got_data[k] !== exp_sample(0, k) || got_comp[k] !== 2'(k / 64) || got_bs[k] !== (k % 64 == 0)) begin
        tests_failed++;
        $display("[TB] FAIL bp xfer %0d got d=%h c=%0d bs=%b exp d=%h c=%0d bs=%b", k, got_data[k], got_comp[k], got_bs[k], exp_sample(0, k), k / 64, (k % 64 == 0));
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    do_reset();
    ready_in = 1'b1;
    for (int i = 0; i < 128; i++) begin
      enable  = 1'b1;
      data_in = pix(i);
      tick();
    end
    drain(384, 800);
    tests_run++;
    if (got_data.size() != 384) begin tests_failed++; $display("[TB] FAIL b2b count got=%0d exp=384", got_data.size()); end
    if (got_data.size() >= 384) begin
      tests_run++;
      if (got_cyc[383] - got_cyc[0] != 383) begin tests_failed++; $display("[TB] FAIL b2b no_bubble span=%0d exp=383", got_cyc[383] - got_cyc[0]); end
    end
    for (int k = 0; k < got_data.size() && k < 384; k++) begin
      base = (k < 192) ? 0 : 64;
      tests_run++;
      if (got_data[k] !== exp_sample(base, k % 192) || got_comp[k] !== 2'((k % 192) / 64) || got_bs[k] !== (k % 64 == 0)) begin
        tests_failed++;
        $display("[TB] FAIL b2b xfer %0d got d=%h c=%0d bs=%b exp d=%h c=%0d bs=%b", k, got_data[k], got_comp[k], got_bs[k], exp_sample(base, k % 192), (k % 192) / 64, (k % 64 == 0));
      end
    end
  endtask

  task automatic test_overflow();
    int base;
    do_reset();
    ready_in = 1'b0;
    for (int i = 0; i < 128; i++) begin
      enable  = 1'b1;
      data_in = pix(i);
      @(negedge clk);
      if (i == 127) begin
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf in_ready_before_127 got=%b exp=1", in_ready); end
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf early_pulse got=%b exp=0", overflow); end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    enable  = 1'b1;
    data_in = pix(128);
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf in_ready_after_127 got=%b exp=0", in_ready); end
    @(posedge clk);
    #1;
    cyc++;
    enable = 1'b0;
    @(negedge clk);
    tests_run++;
    if (overflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf pulse got=%b exp=1", overflow); end
    @(posedge clk);
    #1;
    cyc++;
    @(negedge clk);
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf pulse_width got=%b exp=0", overflow); end
    @(posedge clk);
    #1;
    cyc++;
    drain(384, 800);
    tests_run++;
    if (got_data.size() != 384) begin tests_failed++; $display("[TB] FAIL ovf count got=%0d exp=384", got_data.size()); end
    for (int k = 0; k < got_data.size() && k < 384; k++) begin
      base = (k < 192) ? 0 : 64;
      tests_run++;
      if (got_data[k] !== exp_sample(base, k % 192) || got_comp[k] !== 2'((k % 192) / 64)) begin
        tests_failed++;
        $display("[TB] FAIL ovf xfer %0d got d=%h c=%0d exp d=%h c=%0d", k, got_data[k], got_comp[k], exp_sample(base, k % 192), (k % 192) / 64);
      end
    end
  endtask

  task automatic test_mid_block_reset();
    do_reset();
    ready_in = 1'b1;
    for (int i = 0; i < 30; i++) begin
      enable  = 1'b1;
      data_in = pix(i);
      tick();
    end
    rst_n  = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    tests_run++;
    if (valid_out !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midrst state got v=%b ir=%b exp v=0 ir=1", valid_out, in_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_log();
    for (int i = 0; i < 64; i++) begin
      enable  = 1'b1;
      data_in = pix(100 + i);
      tick();
    end
    drain(192, 400);
    tests_run++;
    if (got_data.size() != 192) begin tests_failed++; $display("[TB] FAIL midrst count got=%0d exp=192", got_data.size()); end
    for (int k = 0; k < got_data.size() && k < 192; k++) begin
      tests_run++;
      if (got_data[k] !== exp_sample(100, k) || got_comp[k] !== 2'(k / 64) || got_bs[k] !== (k % 64 == 0)) begin
        tests_failed++;
        $display("[TB] FAIL midrst xfer %0d got d=%h c=%0d bs=%b exp d=%h c=%0d bs=%b", k, got_data[k], got_comp[k], got_bs[k], exp_sample(100, k), k / 64, (k % 64 == 0));
      end
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    rst_n        = 1'b0;
    enable       = 1'b0;
    data_in      = '0;
    ready_in     = 1'b0;
    test_reset();
    test_single_block();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_mid_block_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
